// File: rtl/desloc_pkg.sv
// Shared types for the shift-register command sequencer and its register.
package desloc_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_CNT_W = 3;

  typedef enum logic [1:0] {
    OP_HOLD  = 2'b00,
    OP_LEFT  = 2'b01,
    OP_RIGHT = 2'b10,
    OP_LOAD  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_SHIFT   = 3'd2,
    S_CAPTURE = 3'd3,
    S_RESP    = 3'd4
  } state_e;

endpackage

// File: rtl/desloc_seq.sv
// Command sequencer for reg_desloc: load, N shifts, capture, respond.
//
// state     | meaning
// ----------+---------------------------------------------------------
// S_IDLE    | waiting for a command, cmd_ready high, register held
// S_LOAD    | one cycle of parallel load of the latched word
// S_SHIFT   | N cycles of shifting in the latched direction with fill
// S_CAPTURE | one cycle, register output sampled into rsp_data
// S_RESP    | rsp_valid high until the consumer takes the result
module desloc_seq
  import desloc_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             cmd_dir,
  input  logic [CNT_W-1:0] cmd_shifts,
  input  logic             cmd_fill,
  output logic [1:0]       reg_op,
  output logic [WIDTH-1:0] reg_parallel_in,
  output logic             reg_serial_in,
  input  logic [WIDTH-1:0] reg_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             busy
);

  state_e           state;
  op_e              op_q;
  logic             dir_q;
  logic [CNT_W-1:0] cnt;

  assign reg_op = op_q;

  // Sequencer FSM with shift down-counter, command holding register and
  // registered handshake/op outputs updated alongside each transition.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= S_IDLE;
      op_q            <= OP_HOLD;
      dir_q           <= 1'b0;
      cnt             <= '0;
      reg_parallel_in <= '0;
      reg_serial_in   <= 1'b0;
      rsp_data        <= '0;
      rsp_valid       <= 1'b0;
      cmd_ready       <= 1'b1;
      busy            <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            reg_parallel_in <= cmd_data;
            reg_serial_in   <= cmd_fill;
            dir_q           <= cmd_dir;
            cnt             <= cmd_shifts;
            op_q            <= OP_LOAD;
            cmd_ready       <= 1'b0;
            busy            <= 1'b1;
            state           <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (cnt != '0) begin
            op_q  <= dir_q ? OP_RIGHT : OP_LEFT;
            state <= S_SHIFT;
          end else begin
            op_q  <= OP_HOLD;
            state <= S_CAPTURE;
          end
        end
        S_SHIFT: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            op_q  <= OP_HOLD;
            state <= S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          rsp_data  <= reg_out;
          rsp_valid <= 1'b1;
          state     <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: begin
          op_q      <= OP_HOLD;
          rsp_valid <= 1'b0;
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_desloc_seq.sv
// Self-checking bench for desloc_seq with a behavioural stand-in register.
module tb_desloc_seq;

  localparam int W = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_data;
  logic       cmd_dir;
  logic [2:0] cmd_shifts;
  logic       cmd_fill;
  logic [1:0] reg_op;
  logic [3:0] reg_parallel_in;
  logic       reg_serial_in;
  logic [3:0] reg_out;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [3:0] rsp_data;
  logic       busy;

  int checks = 0;
  int errors = 0;

  logic [3:0] q = 4'b0000;
  assign reg_out = q;

  always #5 clk = ~clk;

  // Stand-in for reg_desloc: hold / left / right / load.
  always @(posedge clk) begin
    case (reg_op)
      2'b01:   q <= {q[2:0], reg_serial_in};
      2'b10:   q <= {reg_serial_in, q[3:1]};
      2'b11:   q <= reg_parallel_in;
      default: q <= q;
    endcase
  end

  desloc_seq dut (
    .clk             (clk),
    .reset           (reset),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_data        (cmd_data),
    .cmd_dir         (cmd_dir),
    .cmd_shifts      (cmd_shifts),
    .cmd_fill        (cmd_fill),
    .reg_op          (reg_op),
    .reg_parallel_in (reg_parallel_in),
    .reg_serial_in   (reg_serial_in),
    .reg_out         (reg_out),
    .rsp_valid       (rsp_valid),
    .rsp_ready       (rsp_ready),
    .rsp_data        (rsp_data),
    .busy            (busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Result of loading d and shifting n times, by plain arithmetic.
  function automatic logic [3:0] ref_result(input logic [3:0] d, input logic dr,
                                            input int n, input logic f);
    int v;
    int ones;
    if (n >= W) return f ? 4'hF : 4'h0;
    ones = (1 << n) - 1;
    if (!dr) v = ((int'(d) << n) | (f ? ones : 0)) & 15;
    else     v = (int'(d) >> n) | (f ? (ones << (W - n)) : 0);
    return 4'(v);
  endfunction

  task automatic run_cmd(input logic [3:0] d, input logic dr, input int n,
                         input logic f, input int bp);
    logic [3:0] exp;
    int waited;
    exp = ref_result(d, dr, n, f);
    waited = 0;
    while (cmd_ready !== 1'b1 && waited < 20) begin
      step();
      waited++;
    end
    chk("ready_before_cmd", {7'd0, cmd_ready}, 8'd1);
    cmd_valid = 1'b1; cmd_data = d; cmd_dir = dr; cmd_shifts = 3'(n); cmd_fill = f;
    rsp_ready = 1'b0;
    step();
    cmd_valid = 1'b0; cmd_data = 4'($urandom); cmd_dir = ~dr;
    cmd_shifts = 3'($urandom); cmd_fill = ~f;
    chk("load_op", {6'd0, reg_op}, 8'd3);
    chk("load_word", {4'd0, reg_parallel_in}, {4'd0, d});
    chk("busy_load", {7'd0, busy}, 8'd1);
    chk("ready_low_load", {7'd0, cmd_ready}, 8'd0);
    for (int i = 0; i < n; i++) begin
      step();
      chk("shift_op", {6'd0, reg_op}, dr ? 8'd2 : 8'd1);
      chk("shift_fill", {7'd0, reg_serial_in}, {7'd0, f});
    end
    step();
    chk("capture_op", {6'd0, reg_op}, 8'd0);
    chk("capture_no_valid", {7'd0, rsp_valid}, 8'd0);
    step();
    chk("resp_valid", {7'd0, rsp_valid}, 8'd1);
    chk("resp_data", {4'd0, rsp_data}, {4'd0, exp});
    chk("resp_op", {6'd0, reg_op}, 8'd0);
    for (int k = 0; k < bp; k++) begin
      cmd_valid = 1'b1; cmd_data = ~d; rsp_ready = 1'b0;
      step();
      chk("bp_valid", {7'd0, rsp_valid}, 8'd1);
      chk("bp_data", {4'd0, rsp_data}, {4'd0, exp});
      chk("bp_ready_low", {7'd0, cmd_ready}, 8'd0);
      chk("bp_word_kept", {4'd0, reg_parallel_in}, {4'd0, d});
    end
    cmd_valid = 1'b0; rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("after_hs_valid", {7'd0, rsp_valid}, 8'd0);
    chk("after_hs_ready", {7'd0, cmd_ready}, 8'd1);
    chk("after_hs_busy", {7'd0, busy}, 8'd0);
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_data = '0; cmd_dir = 1'b0;
    cmd_shifts = '0; cmd_fill = 1'b0; rsp_ready = 1'b0;
    step();
    step();
    reset = 1'b0;
    chk("rst_ready", {7'd0, cmd_ready}, 8'd1);
    chk("rst_busy", {7'd0, busy}, 8'd0);
    chk("rst_op", {6'd0, reg_op}, 8'd0);
    chk("rst_valid", {7'd0, rsp_valid}, 8'd0);
    chk("rst_data", {4'd0, rsp_data}, 8'd0);
    chk("rst_pin", {4'd0, reg_parallel_in}, 8'd0);
    chk("rst_sin", {7'd0, reg_serial_in}, 8'd0);

    // Directed cases.
    run_cmd(4'b1010, 1'b0, 1, 1'b1, 0);
    chk("dir_left1", {4'd0, rsp_data}, 8'h05);
    run_cmd(4'b1111, 1'b1, 4, 1'b0, 0);
    chk("dir_right4", {4'd0, rsp_data}, 8'h00);
    run_cmd(4'b0110, 1'b0, 0, 1'b0, 0);
    chk("dir_zero", {4'd0, rsp_data}, 8'h06);
    run_cmd(4'b0011, 1'b1, 7, 1'b1, 3);
    chk("dir_bp_max", {4'd0, rsp_data}, 8'h0F);

    // Reset in the second shift cycle of a 7-shift command.
    cmd_valid = 1'b1; cmd_data = 4'b1011; cmd_dir = 1'b0; cmd_shifts = 3'd7; cmd_fill = 1'b0;
    step();
    cmd_valid = 1'b0;
    step();
    step();
    chk("mid_shift_op", {6'd0, reg_op}, 8'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mr_ready", {7'd0, cmd_ready}, 8'd1);
    chk("mr_busy", {7'd0, busy}, 8'd0);
    chk("mr_op", {6'd0, reg_op}, 8'd0);
    chk("mr_valid", {7'd0, rsp_valid}, 8'd0);
    chk("mr_data", {4'd0, rsp_data}, 8'd0);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("mr_no_valid", {7'd0, rsp_valid}, 8'd0);
      chk("mr_reg_held", {4'd0, reg_out}, 8'h0C);
    end
    run_cmd(4'b1001, 1'b0, 0, 1'b0, 0);
    chk("mr_follow", {4'd0, rsp_data}, 8'h09);

    // Reset while a response is pending drops it.
    run_cmd(4'b0101, 1'b1, 2, 1'b1, 0);
    cmd_valid = 1'b1; cmd_data = 4'b1100; cmd_dir = 1'b1; cmd_shifts = 3'd0; cmd_fill = 1'b0;
    step();
    cmd_valid = 1'b0;
    step();
    step();
    chk("pend_valid", {7'd0, rsp_valid}, 8'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("pend_dropped", {7'd0, rsp_valid}, 8'd0);
    chk("pend_data_clr", {4'd0, rsp_data}, 8'd0);

    // Randomized commands against the arithmetic reference.
    for (int t = 0; t < 30; t++) begin
      logic [3:0] d;
      logic       dr;
      logic       f;
      int         n;
      int         bp;
      d  = 4'($urandom);
      dr = 1'($urandom);
      f  = 1'($urandom);
      n  = int'($urandom_range(0, 7));
      bp = int'($urandom_range(0, 3));
      run_cmd(d, dr, n, f, bp);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/desloc_seq.md
# desloc_seq

Command sequencer for the 4-bit shift register (`reg_desloc`, op encoding 00 hold / 01 left / 10 right / 11 load). It accepts a word plus shift command over a valid/ready handshake and drives the register through load, N shifts and capture. It returns the final register contents over a valid/ready response channel. It sits beside `reg_desloc` in the `desloc_unit` wrapper and is the only driver of the register's `op`, `parallel_in` and `serial_in`.

## Interface
- WIDTH, 4, register width; matches `reg_desloc`
- CNT_W, 3, shift-count width; max shifts per command = 2^CNT_W-1
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept; high only in IDLE
- cmd_data  in  WIDTH  word to parallel-load
- cmd_dir  in  1  0 = shift left (op 01), 1 = shift right (op 10)
- cmd_shifts  in  CNT_W  shifts after load; 0 allowed
- cmd_fill  in  1  serial_in value during shifting
- reg_op  out  2  op to register
- reg_parallel_in  out  WIDTH  load word to register
- reg_serial_in  out  1  serial bit to register
- reg_out  in  WIDTH  register output (registered in `reg_desloc`)
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_data  out  WIDTH  captured register value
- busy  out  1  high in any state other than IDLE

## Operation
- States: IDLE, LOAD, SHIFT, CAPTURE, RESP.
- IDLE: cmd_ready=1, reg_op=00. On cmd_valid&&cmd_ready, latch data/dir/shifts/fill and go to LOAD.
- LOAD (1 cycle): reg_op=11, reg_parallel_in=latched data. Next is SHIFT if shifts≠0, else CAPTURE.
- SHIFT (N cycles): reg_op=01 or 10 per dir, reg_serial_in=fill. The counter loads N at accept and decrements each SHIFT cycle. Leave SHIFT when the counter is 1.
- Register semantics relied on: left = {q[W-2:0], fill}, right = {fill, q[W-1:1]}. N ≥ WIDTH yields all bits = fill.
- CAPTURE (1 cycle): reg_op=00; rsp_data ← reg_out at end of cycle; go to RESP.
- RESP: rsp_valid=1, rsp_data stable, reg_op=00. On rsp_ready, go to IDLE.
- reg_parallel_in and reg_serial_in hold their latched values outside LOAD/SHIFT. They are meaningful only when op selects them.
- cmd_valid outside IDLE is ignored; the command is not latched.

## Timing
- Reset values: state IDLE, cmd_ready=1, busy=0, reg_op=00, reg_parallel_in=0, reg_serial_in=0, rsp_valid=0, rsp_data=0, counter=0.
- Accept in cycle 0. LOAD in cycle 1, SHIFT in cycles 2..N+1, CAPTURE in cycle N+2. rsp_valid is first high in cycle N+3.
- Minimum cycle-to-cycle throughput: N+4 cycles per command with rsp_ready held high. The next cmd_ready is in the cycle after the response handshake; no overlap.
- rsp_valid, once high, stays high with rsp_data unchanged until the rsp_ready handshake.
- Reset mid-operation (any state): next cycle is IDLE with reset values. The in-flight command and any pending response are dropped. Register contents are left unchanged (op=00).
- All outputs are registered or decoded from state only; there are no combinational paths from cmd_* or rsp_ready to outputs.

## Structure
- Package `desloc_pkg`: `op_e` enum (OP_HOLD=2'b00, OP_LEFT=2'b01, OP_RIGHT=2'b10, OP_LOAD=2'b11), `state_e` enum for the five states, default WIDTH/CNT_W constants. `reg_desloc` and the wrapper import the same `op_e`.
- No sub-module inside `desloc_seq`: one FSM, a down-counter and a command holding register. `desloc_unit` instantiates `desloc_seq` and `reg_desloc`.

## Test plan
- Reset asserted 2 cycles then released -> cmd_ready=1, busy=0, reg_op=00, rsp_valid=0, rsp_data=0000.
- data=1010, dir=0, shifts=1, fill=1, rsp_ready=1 -> reg_op 11,01,00 in cycles 1-3; rsp_valid in cycle 4 with rsp_data=0101.
- data=1111, dir=1, shifts=4, fill=0 -> four cycles of op=10; rsp_valid in cycle 7, rsp_data=0000.
- data=0110, shifts=0 -> op 11 then 00; rsp_valid in cycle 3, rsp_data=0110.
- Backpressure: rsp_ready low 3 cycles in RESP while cmd_valid high with new data -> rsp_valid/rsp_data held, cmd_ready=0, new command not accepted until the handshake completes.
- Reset asserted in 2nd SHIFT cycle of a shifts=7 command -> next cycle IDLE, reg_op=00, rsp_valid never rises; a following command (data=1001, shifts=0) returns 1001.
